// File: rtl/bicubic_sched_pkg.sv
// rtl/bicubic_sched_pkg.sv - shared state encoding and round/clamp constants for the bicubic scheduler
package bicubic_sched_pkg;

    localparam int PRODUCT_WIDTH = 16;
    localparam int PIX_WIDTH     = 8;
    localparam int WEIGHT_SHIFT  = 3;
    localparam int MAG_W         = PRODUCT_WIDTH - 1;

    localparam logic [MAG_W:0]         ROUND_HALF = (MAG_W + 1)'(1) << (WEIGHT_SHIFT - 1);
    localparam logic [MAG_W-1:0]       MAG_SAT    = '1;
    localparam logic [MAG_W-1:0]       PIX_LIMIT  = MAG_W'(255);
    localparam logic [PIX_WIDTH-1:0]   PIX_MAX    = '1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_H0,
        ST_H1,
        ST_H2,
        ST_H3,
        ST_V,
        ST_OUT
    } sched_state_t;

endpackage

// File: rtl/bicubic_round_clamp.sv
// rtl/bicubic_round_clamp.sv - sign-magnitude round-shift plus 8-bit clamp and clamp flag
module bicubic_round_clamp
    import bicubic_sched_pkg::*;
(
    input  logic [PRODUCT_WIDTH-1:0] sm_in,
    output logic [PRODUCT_WIDTH-1:0] sm_round,
    output logic [PIX_WIDTH-1:0]     pix,
    output logic                     clamp
);

    logic [MAG_W:0]   sum;
    logic [MAG_W-1:0] mag_r;
    logic             neg;
    logic             sat_hi;

    always_comb begin
        sum      = {1'b0, sm_in[MAG_W-1:0]} + ROUND_HALF;
        mag_r    = MAG_W'(sum >> WEIGHT_SHIFT);
        // A magnitude that rounds to zero is always emitted as +0.
        neg      = sm_in[MAG_W] && (mag_r != '0);
        sm_round = {neg, mag_r};
        sat_hi   = !neg && ((mag_r > PIX_LIMIT) || (sm_in[MAG_W-1:0] == MAG_SAT));
        clamp    = neg || sat_hi;
        if (neg)
            pix = '0;
        else if (sat_hi)
            pix = PIX_MAX;
        else
            pix = mag_r[PIX_WIDTH-1:0];
    end

endmodule

// File: rtl/bicubic_vector_mult.sv
// rtl/bicubic_vector_mult.sv - combinational 4-tap sign-magnitude dot product, magnitude saturating
module bicubic_vector_mult #(
    parameter int PRODUCT_WIDTH = 16
) (
    input  logic [4*PRODUCT_WIDTH-1:0] operands,
    input  logic [15:0]                weights,
    output logic [PRODUCT_WIDTH-1:0]   product
);

    localparam int MW = PRODUCT_WIDTH - 1;
    localparam int AW = MW + 6;

    logic signed [AW-1:0] acc;
    logic        [AW-1:0] term;
    logic        [AW-1:0] abs_acc;

    always_comb begin
        acc  = '0;
        term = '0;
        for (int i = 0; i < 4; i++) begin
            term = AW'(operands[i*PRODUCT_WIDTH +: MW]) * AW'(weights[i*4 +: 3]);
            if (operands[i*PRODUCT_WIDTH + MW] ^ weights[i*4 + 3])
                acc = acc - $signed(term);
            else
                acc = acc + $signed(term);
        end
        abs_acc = acc[AW-1] ? $unsigned(-acc) : $unsigned(acc);
        if (abs_acc > AW'({MW{1'b1}}))
            product = {acc[AW-1], {MW{1'b1}}};
        else
            product = {acc[AW-1], abs_acc[MW-1:0]};
    end

endmodule

// File: rtl/bicubic_conv_sched.sv
// rtl/bicubic_conv_sched.sv - 4x4 bicubic convolution scheduler around one shared vector multiplier
// Optional clamp-event counter on sat_cnt when BICUBIC_SCHED_SAT_CNT_EN is defined.
module bicubic_conv_sched
    import bicubic_sched_pkg::*;
(
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [16*PIX_WIDTH-1:0]   win_pix,
    input  logic [15:0]               wx,
    input  logic [15:0]               wy,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PIX_WIDTH-1:0]      out_pix
`ifdef BICUBIC_SCHED_SAT_CNT_EN
    ,
    output logic [15:0]               sat_cnt
`endif
);

    sched_state_t                  state;
    logic [16*PIX_WIDTH-1:0]       win_q;
    logic [15:0]                   wx_q;
    logic [15:0]                   wy_q;
    logic [3:0][PRODUCT_WIDTH-1:0] row_buf;
    logic [1:0]                    row_sel;
    logic [4*PRODUCT_WIDTH-1:0]    mult_operands;
    logic [15:0]                   mult_weights;
    logic [PRODUCT_WIDTH-1:0]      mult_product;
    logic [PRODUCT_WIDTH-1:0]      rc_sm;
    logic [PIX_WIDTH-1:0]          rc_pix;
    logic                          rc_clamp;

    always_comb begin
        row_sel = 2'd0;
        case (state)
            ST_H1:   row_sel = 2'd1;
            ST_H2:   row_sel = 2'd2;
            ST_H3:   row_sel = 2'd3;
            default: row_sel = 2'd0;
        endcase
    end

    // Horizontal passes feed one window row; the vertical pass feeds the buffered row results.
    always_comb begin
        mult_operands = '0;
        mult_weights  = wx_q;
        if (state == ST_V) begin
            mult_operands = row_buf;
            mult_weights  = wy_q;
        end else begin
            for (int c = 0; c < 4; c++)
                mult_operands[c*PRODUCT_WIDTH +: PRODUCT_WIDTH] =
                    PRODUCT_WIDTH'(win_q[(row_sel*4 + c)*PIX_WIDTH +: PIX_WIDTH]);
        end
    end

    bicubic_vector_mult #(
        .PRODUCT_WIDTH(PRODUCT_WIDTH)
    ) u_mult (
        .operands(mult_operands),
        .weights (mult_weights),
        .product (mult_product)
    );

    bicubic_round_clamp u_round_clamp (
        .sm_in   (mult_product),
        .sm_round(rc_sm),
        .pix     (rc_pix),
        .clamp   (rc_clamp)
    );

`ifndef BICUBIC_SCHED_SAT_CNT_EN
    logic unused_clamp;
    assign unused_clamp = rc_clamp;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= ST_IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_pix   <= '0;
            row_buf   <= '0;
            win_q     <= '0;
            wx_q      <= '0;
            wy_q      <= '0;
`ifdef BICUBIC_SCHED_SAT_CNT_EN
            sat_cnt   <= '0;
`endif
        end else begin
            case (state)
                ST_IDLE: begin
                    if (in_valid && in_ready) begin
                        win_q    <= win_pix;
                        wx_q     <= wx;
                        wy_q     <= wy;
                        in_ready <= 1'b0;
                        state    <= ST_H0;
                    end
                end
                ST_H0, ST_H1, ST_H2, ST_H3: begin
                    row_buf[row_sel] <= rc_sm;
                    state <= (state == ST_H3) ? ST_V : sched_state_t'(state + 3'd1);
                end
                ST_V: begin
                    out_pix   <= rc_pix;
                    out_valid <= 1'b1;
                    state     <= ST_OUT;
`ifdef BICUBIC_SCHED_SAT_CNT_EN
                    if (rc_clamp && (sat_cnt != 16'hFFFF))
                        sat_cnt <= sat_cnt + 16'd1;
`endif
                end
                ST_OUT: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= ST_IDLE;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bicubic_conv_sched.sv
// tb/tb_bicubic_conv_sched.sv - table, corner-sequence and randomized checks of bicubic_conv_sched
module tb_bicubic_conv_sched;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] win_pix;
    logic [15:0]  wx;
    logic [15:0]  wy;
    logic         out_valid;
    logic         out_ready;
    logic [7:0]   out_pix;
`ifdef BICUBIC_SCHED_SAT_CNT_EN
    logic [15:0]  sat_cnt;
    int           exp_sat = 0;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int cyc   = 0;
    bit mon_en = 1'b0;
    logic [7:0] got[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(negedge clk) if (mon_en && out_valid && out_ready) got.push_back(out_pix);

    bicubic_conv_sched dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .win_pix  (win_pix),
        .wx       (wx),
        .wy       (wy),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pix  (out_pix)
`ifdef BICUBIC_SCHED_SAT_CNT_EN
        ,
        .sat_cnt  (sat_cnt)
`endif
    );

    typedef struct {
        string        name;
        logic [127:0] win;
        logic [15:0]  wx;
        logic [15:0]  wy;
        logic [7:0]   exp_pix;
        bit           exp_clamp;
    } vec_t;

    vec_t tbl[9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [127:0] rowrep(input logic [31:0] row);
        return {row, row, row, row};
    endfunction

    function automatic int wt(input logic [15:0] w, input int i);
        logic [3:0] n;
        n = w[i*4 +: 4];
        return n[3] ? -int'(n[2:0]) : int'(n[2:0]);
    endfunction

    function automatic int sm_round(input int v, output bit sat);
        int m;
        m = (v < 0) ? -v : v;
        sat = (m >= 32767);
        if (m > 32767) m = 32767;
        m = (m + 4) / 8;
        return (v < 0) ? -m : m;
    endfunction

    // Reference: integer dot products per row, then over rows, half-away rounding, clamp.
    function automatic void model(input logic [127:0] w, input logic [15:0] x, input logic [15:0] y,
                                  output logic [7:0] p, output bit clamp);
        int rows[4];
        int acc;
        int v;
        bit s;
        for (int r = 0; r < 4; r++) begin
            acc = 0;
            for (int c = 0; c < 4; c++)
                acc += wt(x, c) * int'(w[(r*4 + c)*8 +: 8]);
            rows[r] = sm_round(acc, s);
        end
        acc = 0;
        for (int r = 0; r < 4; r++)
            acc += wt(y, r) * rows[r];
        v = sm_round(acc, s);
        if (v < 0) begin
            p = 8'd0;   clamp = 1'b1;
        end else if (v > 255 || s) begin
            p = 8'd255; clamp = 1'b1;
        end else begin
            p = 8'(v);  clamp = 1'b0;
        end
    endfunction

    task automatic send(input logic [127:0] w, input logic [15:0] x, input logic [15:0] y,
                        output int t_acc);
        int n;
        n = 0;
        win_pix = w; wx = x; wy = y; in_valid = 1'b1;
        while (!in_ready && n < 50) begin
            step();
            n++;
        end
        check("accept_ready", in_ready, 1);
        t_acc = cyc;
        step();
        in_valid = 1'b0;
    endtask

    task automatic wait_out(output int t_out);
        int n;
        n = 0;
        while (!out_valid && n < 50) begin
            step();
            n++;
        end
        t_out = cyc;
    endtask

    task automatic run_vec(input string name, input logic [127:0] w, input logic [15:0] x,
                           input logic [15:0] y, input logic [7:0] ep, input bit ec);
        int ta;
        int to;
        send(w, x, y, ta);
        wait_out(to);
        check({name, "_latency"}, to - ta, 6);
        check({name, "_pix"}, out_pix, ep);
`ifdef BICUBIC_SCHED_SAT_CNT_EN
        if (ec) exp_sat++;
        check({name, "_sat_cnt"}, sat_cnt, exp_sat);
`else
        if (ec) n_vec = n_vec;
`endif
        step();
    endtask

    initial begin
        logic [127:0] w;
        logic [15:0]  x;
        logic [15:0]  y;
        logic [7:0]   ep;
        bit           ec;
        int           ta;
        int           to;
        int           n;
        bit           seen;
        logic [7:0]   bb_exp[4];
        int           bb_acc[4];

        tbl[0] = '{"flat",      rowrep(32'h64646464), 16'h9559, 16'h9559, 8'd100, 1'b0};
        tbl[1] = '{"neg_clamp", rowrep(32'hFF0000FF), 16'h9559, 16'h9559, 8'd0,   1'b1};
        tbl[2] = '{"pos_clamp", rowrep(32'h00FFFF00), 16'h9559, 16'h9559, 8'd255, 1'b1};
        tbl[3] = '{"zero",      128'd0,               16'h7777, 16'h7777, 8'd0,   1'b0};
        tbl[4] = '{"edge_255",  rowrep(32'hFFFFFFFF), 16'h0440, 16'h0440, 8'd255, 1'b0};
        tbl[5] = '{"neg_zero",  rowrep(32'h00000001), 16'h0009, 16'h7777, 8'd0,   1'b0};
        tbl[6] = '{"half_up",   rowrep(32'h01010101), 16'h1111, 16'h1111, 8'd1,   1'b0};
        tbl[7] = '{"below_half",rowrep(32'h01010101), 16'h0111, 16'h1111, 8'd0,   1'b0};
        tbl[8] = '{"neg_half",  rowrep(32'h01010101), 16'h9999, 16'h9999, 8'd1,   1'b0};

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        win_pix = '0; wx = '0; wy = '0;
        repeat (3) step();
        check("reset_in_ready", in_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_out_pix", out_pix, 0);
`ifdef BICUBIC_SCHED_SAT_CNT_EN
        check("reset_sat_cnt", sat_cnt, 0);
`endif
        rst = 1'b0;
        step();

        for (int i = 0; i < 9; i++)
            run_vec(tbl[i].name, tbl[i].win, tbl[i].wx, tbl[i].wy, tbl[i].exp_pix, tbl[i].exp_clamp);

        // Backpressure: result must hold while out_ready is low; a new window waits.
        out_ready = 1'b0;
        send(rowrep(32'h64646464), 16'h9559, 16'h9559, ta);
        wait_out(to);
        check("bp_latency", to - ta, 6);
        win_pix = rowrep(32'h00FFFF00); in_valid = 1'b1;
        for (int k = 0; k < 3; k++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_out_pix", out_pix, 100);
            check("bp_in_ready", in_ready, 0);
            step();
        end
        out_ready = 1'b1;
        step();
        check("bp_release_valid", out_valid, 0);
        check("bp_release_ready", in_ready, 1);
        ta = cyc;
        step();
        check("bp_accept", in_ready, 0);
        in_valid = 1'b0;
        wait_out(to);
        check("bp2_latency", to - ta, 6);
        check("bp2_pix", out_pix, 255);
`ifdef BICUBIC_SCHED_SAT_CNT_EN
        exp_sat++;
        check("bp2_sat_cnt", sat_cnt, exp_sat);
`endif
        step();

        // Reset asserted while the third horizontal pass is in flight.
        send(rowrep(32'h64646464), 16'h9559, 16'h9559, ta);
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
`ifdef BICUBIC_SCHED_SAT_CNT_EN
        exp_sat = 0;
        check("rst_sat_cnt", sat_cnt, 0);
`endif
        seen = 1'b0;
        repeat (10) begin
            if (out_valid) seen = 1'b1;
            step();
        end
        check("rst_no_output", seen, 0);

        // Back-to-back windows with continuous in_valid and out_ready.
        got.delete();
        mon_en = 1'b1;
        for (int k = 0; k < 4; k++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            x = 16'($urandom());
            y = 16'($urandom());
            model(w, x, y, bb_exp[k], ec);
`ifdef BICUBIC_SCHED_SAT_CNT_EN
            if (ec) exp_sat++;
`endif
            send(w, x, y, bb_acc[k]);
        end
        n = 0;
        while (got.size() < 4 && n < 60) begin
            step();
            n++;
        end
        mon_en = 1'b0;
        check("b2b_count", got.size(), 4);
        for (int k = 0; k < 4; k++)
            check("b2b_pix", (k < got.size()) ? got[k] : 8'hxx, bb_exp[k]);
        for (int k = 1; k < 4; k++)
            check("b2b_spacing", bb_acc[k] - bb_acc[k-1], 7);
`ifdef BICUBIC_SCHED_SAT_CNT_EN
        check("b2b_sat_cnt", sat_cnt, exp_sat);
`endif
        step();

        for (int i = 0; i < 30; i++) begin
            w = {$urandom(), $urandom(), $urandom(), $urandom()};
            x = 16'($urandom());
            y = 16'($urandom());
            if (i % 3 == 0) begin
                x = x & 16'h3333;
                y = y & 16'h3333;
            end
            model(w, x, y, ep, ec);
            run_vec("rand", w, x, y, ep, ec);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
